// File: rtl/neptuno_joy_shifter_pkg.sv
// Shared constants for the Neptuno twin-joystick serial front end.
// Holds FSM state codes, frame layout (player byte positions, button bit
// offsets) and a helper that extracts one player's six buttons from a frame.
package neptuno_joy_pkg;

  localparam int unsigned NBITS_FIXED = 16;
  localparam int unsigned FRAME_TICKS = 34;
  localparam int unsigned JOY_W       = 6;

  // Player field base positions within the serial frame
  localparam int unsigned JOY1_LSB = 0;
  localparam int unsigned JOY2_LSB = 8;

  // Button offsets within a player field
  localparam int unsigned UP    = 0;
  localparam int unsigned DOWN  = 1;
  localparam int unsigned LEFT  = 2;
  localparam int unsigned RIGHT = 3;
  localparam int unsigned FIRE1 = 4;
  localparam int unsigned FIRE2 = 5;

  localparam int unsigned STATE_W = 2;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_LOAD = 2'd0;
  localparam state_t ST_LOW  = 2'd1;
  localparam state_t ST_HIGH = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Pick out one player's buttons {fire2,fire1,right,left,down,up}
  function automatic logic [JOY_W-1:0] joy_decode(input logic [NBITS_FIXED-1:0] frame,
                                                   input int unsigned lsb);
    logic [NBITS_FIXED-1:0] s;
    logic [JOY_W-1:0]       j;
    s        = frame >> lsb;
    j        = '0;
    j[UP]    = s[UP];
    j[DOWN]  = s[DOWN];
    j[LEFT]  = s[LEFT];
    j[RIGHT] = s[RIGHT];
    j[FIRE1] = s[FIRE1];
    j[FIRE2] = s[FIRE2];
    return j;
  endfunction

endpackage

// File: rtl/neptuno_joy_shifter_if.sv
// Board-side pins and decoded outputs of the joystick shifter.
//   joy_data_i : serial data from the shift-register QH pin
//   joy_load_o : parallel load (active-low), joy_clk_o : shift clock
//   joy1_o/joy2_o : active-low buttons, raw_o : accepted frame,
//   frame_o : one-cycle strobe per accepted frame
// master = shifter side, slave = board / consumer side.
interface neptuno_joy_shifter_if;
  import neptuno_joy_pkg::*;

  logic                   joy_data_i;
  logic                   joy_load_o;
  logic                   joy_clk_o;
  logic [JOY_W-1:0]       joy1_o;
  logic [JOY_W-1:0]       joy2_o;
  logic [NBITS_FIXED-1:0] raw_o;
  logic                   frame_o;

  modport master (input  joy_data_i,
                  output joy_load_o, joy_clk_o, joy1_o, joy2_o, raw_o, frame_o);

  modport slave  (output joy_data_i,
                  input  joy_load_o, joy_clk_o, joy1_o, joy2_o, raw_o, frame_o);

endinterface

// File: rtl/neptuno_joy_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
//   clk_i, rst_i (async, active-high) ; d_i : async input ; q_o : synchronised
// RST_VAL sets the value both flops take during reset.
module neptuno_joy_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/neptuno_joy_shifter.sv
// Serial front end for the Neptuno twin-joystick port.
// Drives load/shift-clock pins of the cascaded PISO registers, deserialises
// a 16-bit frame and publishes it only when two consecutive frames agree.
//   clk_i, rst_i (async, active-high)
//   joy : master modport (data pin in; load/clk pins, buttons, raw, strobe out)
module neptuno_joy_shifter
  import neptuno_joy_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50,
  parameter int unsigned NBITS   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  neptuno_joy_shifter_if.master joy
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam int unsigned IDX_W = $clog2(NBITS_FIXED);

  if (NBITS != NBITS_FIXED) begin : g_nbits_chk
    $error("neptuno_joy_shifter: NBITS must be 16");
  end
  if (CLK_DIV < 4) begin : g_div_chk
    $error("neptuno_joy_shifter: CLK_DIV must be at least 4");
  end
  if (FRAME_TICKS != 2 + 2 * NBITS_FIXED) begin : g_frame_chk
    $error("neptuno_joy_shifter: frame tick budget inconsistent");
  end

  logic data_sync;

  neptuno_joy_sync #(.RST_VAL(1'b1)) u_data_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (joy.joy_data_i),
    .q_o   (data_sync)
  );

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q,   cnt_d;
  logic [IDX_W-1:0]       idx_q,   idx_d;
  logic [NBITS_FIXED-1:0] shift_q, shift_d;
  logic [NBITS_FIXED-1:0] prev_q,  prev_d;
  logic [NBITS_FIXED-1:0] raw_q,   raw_d;
  logic [JOY_W-1:0]       joy1_q,  joy1_d;
  logic [JOY_W-1:0]       joy2_q,  joy2_d;
  logic                   frame_q, frame_d;
  logic                   load_q,  load_d;
  logic                   pclk_q,  pclk_d;
  logic                   tick_c;

  assign tick_c = (cnt_q == CNT_W'(CLK_DIV - 1));

  // Next-state, datapath and pin decode
  always_comb begin
    state_d = state_q;
    cnt_d   = tick_c ? '0 : cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    prev_d  = prev_q;
    raw_d   = raw_q;
    joy1_d  = joy1_q;
    joy2_d  = joy2_q;
    frame_d = 1'b0;
    // Pins follow the current state one clock later, so both are clean flop
    // outputs and load-low / clk-high can never overlap.
    load_d  = (state_q != ST_LOAD);
    pclk_d  = (state_q == ST_HIGH);

    case (state_q)
      ST_LOAD: begin
        // idx doubles as the two-tick load-width counter
        if (tick_c) begin
          if (idx_q[0]) begin
            idx_d   = '0;
            state_d = ST_LOW;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      ST_LOW: begin
        if (tick_c) begin
          shift_d[idx_q] = data_sync;
          state_d        = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (tick_c) begin
          if (idx_q == IDX_W'(NBITS_FIXED - 1)) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_LOW;
          end
        end
      end
      ST_DONE: begin
        // Single-clock evaluation; publish only if this frame matches the last
        cnt_d   = '0;
        idx_d   = '0;
        prev_d  = shift_q;
        state_d = ST_LOAD;
        if (shift_q == prev_q) begin
          raw_d   = shift_q;
          joy1_d  = joy_decode(shift_q, JOY1_LSB);
          joy2_d  = joy_decode(shift_q, JOY2_LSB);
          frame_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_LOAD;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '1;
      prev_q  <= '1;
      raw_q   <= '1;
      joy1_q  <= '1;
      joy2_q  <= '1;
      frame_q <= 1'b0;
      load_q  <= 1'b1;
      pclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      prev_q  <= prev_d;
      raw_q   <= raw_d;
      joy1_q  <= joy1_d;
      joy2_q  <= joy2_d;
      frame_q <= frame_d;
      load_q  <= load_d;
      pclk_q  <= pclk_d;
    end
  end

  assign joy.joy_load_o = load_q;
  assign joy.joy_clk_o  = pclk_q;
  assign joy.joy1_o     = joy1_q;
  assign joy.joy2_o     = joy2_q;
  assign joy.raw_o      = raw_q;
  assign joy.frame_o    = frame_q;

endmodule

// File: tb/tb_neptuno_joy_shifter.sv
// Bench for neptuno_joy_shifter: one instance at CLK_DIV=50 for pin timing,
// filtering and reset, one at CLK_DIV=4 for table and random frames.
// Each instance is driven by a behavioural PISO board model.
module tb_neptuno_joy_shifter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  neptuno_joy_shifter_if if50 ();
  neptuno_joy_shifter_if if4 ();

  neptuno_joy_shifter #(.CLK_DIV(50), .NBITS(16)) u50 (.clk_i(clk), .rst_i(rst), .joy(if50));
  neptuno_joy_shifter #(.CLK_DIV(4),  .NBITS(16)) u4  (.clk_i(clk), .rst_i(rst), .joy(if4));

  int checks = 0;
  int fails  = 0;

  // Board model: continuous parallel load while load pin low, shift on clk rise
  logic [15:0] pat50 = 16'hFFFF, pat4 = 16'hFFFF;
  logic [15:0] sr50 = 16'hFFFF,  sr4 = 16'hFFFF;
  logic        pc50 = 1'b0, pc4 = 1'b0;
  logic        stuck50 = 1'b0;

  always @(negedge clk) begin
    if (!if50.joy_load_o)                sr50 = pat50;
    else if (if50.joy_clk_o && !pc50)    sr50 = {1'b1, sr50[15:1]};
    pc50 = if50.joy_clk_o;
    if50.joy_data_i = stuck50 ? 1'b0 : sr50[0];
    if (!if4.joy_load_o)                 sr4 = pat4;
    else if (if4.joy_clk_o && !pc4)      sr4 = {1'b1, sr4[15:1]};
    pc4 = if4.joy_clk_o;
    if4.joy_data_i = sr4[0];
  end

  // Monitors: frame strobes, shift-clock rises, load/clk overlap
  int fcnt [2] = '{0, 0};
  int rises[2] = '{0, 0};
  int overlap = 0;
  logic mp50 = 1'b0, mp4 = 1'b0;
  always @(negedge clk) begin
    if (if50.frame_o) fcnt[0]++;
    if (if4.frame_o)  fcnt[1]++;
    if (if50.joy_clk_o && !mp50) rises[0]++;
    if (if4.joy_clk_o && !mp4)   rises[1]++;
    mp50 = if50.joy_clk_o;
    mp4  = if4.joy_clk_o;
    if (!if50.joy_load_o && if50.joy_clk_o) overlap++;
    if (!if4.joy_load_o && if4.joy_clk_o)   overlap++;
  end

  // Frame-level reference model per instance
  logic [15:0] m_prev[2], m_raw[2], cur[2];
  bit          started[2];
  int          fbase[2];

  function automatic logic pin(input int d, input int sel);
    case (sel)
      0:       return (d == 0) ? if50.joy_load_o : if4.joy_load_o;
      1:       return (d == 0) ? if50.joy_clk_o  : if4.joy_clk_o;
      default: return (d == 0) ? if50.frame_o    : if4.frame_o;
    endcase
  endfunction

  function automatic logic [15:0] raw_of(input int d);
    return (d == 0) ? if50.raw_o : if4.raw_o;
  endfunction
  function automatic logic [5:0] j1_of(input int d);
    return (d == 0) ? if50.joy1_o : if4.joy1_o;
  endfunction
  function automatic logic [5:0] j2_of(input int d);
    return (d == 0) ? if50.joy2_o : if4.joy2_o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_pin(input int d, input int sel, input logic val, output int n);
    n = 0;
    while (pin(d, sel) !== val && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (pin(d, sel) !== val) begin
      checks++;
      fails++;
      $display("FAIL timeout: dut%0d pin%0d never reached %0b", d, sel, val);
      n = -1;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_prev[d]  = 16'hFFFF;
      m_raw[d]   = 16'hFFFF;
      started[d] = 1'b0;
    end
  endtask

  // Re-align model after an idle stretch of >=2 frames with a constant pattern
  task automatic resync(input int d);
    m_prev[d]  = cur[d];
    m_raw[d]   = cur[d];
    started[d] = 1'b0;
  endtask

  // Wait for next frame start, score the frame just finished, then set pattern
  task automatic next_frame(input int d, input logic [15:0] p);
    int   n;
    logic agree;
    wait_pin(d, 0, 1'b1, n);
    wait_pin(d, 0, 1'b0, n);
    if (started[d]) begin
      agree = (cur[d] == m_prev[d]);
      if (agree) m_raw[d] = cur[d];
      m_prev[d] = cur[d];
      chk($sformatf("raw_d%0d", d),    32'(raw_of(d)), 32'(m_raw[d]));
      chk($sformatf("joy1_d%0d", d),   32'(j1_of(d)),  32'(m_raw[d] & 16'h003F));
      chk($sformatf("joy2_d%0d", d),   32'(j2_of(d)),  32'((m_raw[d] >> 8) & 16'h003F));
      chk($sformatf("strobe_d%0d", d), 32'(fcnt[d] - fbase[d]), agree ? 32'd1 : 32'd0);
    end
    fbase[d]   = fcnt[d];
    started[d] = 1'b1;
    cur[d]     = p;
    if (d == 0) pat50 = p; else pat4 = p;
  endtask

  typedef struct {
    logic [15:0] pat;
    logic [5:0]  j1;
    logic [5:0]  j2;
  } vec_t;

  initial begin
    vec_t        tbl[7];
    int          n, n1, n2, lo_min, lo_max, hi_min, hi_max, rb;
    logic [15:0] p, prev_raw;

    tbl[0] = '{16'hA5C3, 6'h03, 6'h25};
    tbl[1] = '{16'hFFFE, 6'h3E, 6'h3F};
    tbl[2] = '{16'h0000, 6'h00, 6'h00};
    tbl[3] = '{16'h1234, 6'h34, 6'h12};
    tbl[4] = '{16'hC0C0, 6'h00, 6'h00};
    tbl[5] = '{16'h3F00, 6'h00, 6'h3F};
    tbl[6] = '{16'hFFFF, 6'h3F, 6'h3F};

    cur[0] = 16'hFFFF;
    cur[1] = 16'hFFFF;
    fbase[0] = 0;
    fbase[1] = 0;
    model_reset();

    // Reset state for both instances
    repeat (10) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_load_d%0d", d),  32'(pin(d, 0)), 32'd1);
      chk($sformatf("rst_clk_d%0d", d),   32'(pin(d, 1)), 32'd0);
      chk($sformatf("rst_frame_d%0d", d), 32'(pin(d, 2)), 32'd0);
      chk($sformatf("rst_joy1_d%0d", d),  32'(j1_of(d)),  32'h3F);
      chk($sformatf("rst_joy2_d%0d", d),  32'(j2_of(d)),  32'h3F);
      chk($sformatf("rst_raw_d%0d", d),   32'(raw_of(d)), 32'hFFFF);
    end
    rst = 1'b0;

    // First load pulse after release
    wait_pin(0, 0, 1'b0, n);
    chk("first_load_fall_in_div", 32'(n >= 1 && n <= 50), 32'd1);
    wait_pin(0, 0, 1'b1, n);
    chk("first_load_low_width", 32'(n), 32'd100);

    // Shift-clock widths and count within one frame
    rb = rises[0];
    lo_min = 9999; lo_max = 0; hi_min = 9999; hi_max = 0;
    for (int i = 0; i < 16; i++) begin
      wait_pin(0, 1, 1'b1, n1);
      wait_pin(0, 1, 1'b0, n2);
      if (n1 < lo_min) lo_min = n1;
      if (n1 > lo_max) lo_max = n1;
      if (n2 < hi_min) hi_min = n2;
      if (n2 > hi_max) hi_max = n2;
    end
    wait_pin(0, 0, 1'b0, n);
    chk("clk_rises_per_frame", 32'(rises[0] - rb), 32'd16);
    chk("clk_low_min", 32'(lo_min), 32'd50);
    chk("clk_low_max", 32'(lo_max), 32'd50);
    chk("clk_high_min", 32'(hi_min), 32'd50);
    chk("clk_high_max", 32'(hi_max), 32'd50);
    wait_pin(0, 0, 1'b1, n);
    chk("load_low_width", 32'(n), 32'd100);

    // Frame strobe period under steady all-released data
    wait_pin(0, 2, 1'b1, n);
    wait_pin(0, 2, 1'b0, n1);
    wait_pin(0, 2, 1'b1, n2);
    chk("frame_period", 32'(n1 + n2), 32'd1701);

    // Glitch reject: a single FFFE frame must never reach the outputs
    resync(0);
    next_frame(0, 16'hFFFF);
    next_frame(0, 16'hFFFE);
    next_frame(0, 16'hFFFF);
    chk("glitch_joy1_a", 32'(if50.joy1_o), 32'h3F);
    next_frame(0, 16'hFFFF);
    chk("glitch_joy1_b", 32'(if50.joy1_o), 32'h3F);
    next_frame(0, 16'hFFFF);
    chk("glitch_joy1_c", 32'(if50.joy1_o), 32'h3F);
    next_frame(0, 16'hFFFF);

    // Table of static frames on the fast instance
    resync(1);
    next_frame(1, 16'hFFFF);
    prev_raw = 16'hFFFF;
    for (int i = 0; i < 7; i++) begin
      next_frame(1, tbl[i].pat);
      next_frame(1, tbl[i].pat);
      chk($sformatf("tbl%0d_hold_raw", i), 32'(if4.raw_o), 32'(prev_raw));
      next_frame(1, tbl[i].pat);
      chk($sformatf("tbl%0d_raw", i),  32'(if4.raw_o),  32'(tbl[i].pat));
      chk($sformatf("tbl%0d_joy1", i), 32'(if4.joy1_o), 32'(tbl[i].j1));
      chk($sformatf("tbl%0d_joy2", i), 32'(if4.joy2_o), 32'(tbl[i].j2));
      prev_raw = tbl[i].pat;
    end

    // Random patterns held three frames each
    for (int r = 0; r < 20; r++) begin
      p = 16'($urandom);
      next_frame(1, p);
      next_frame(1, p);
      next_frame(1, p);
      chk($sformatf("rand%0d_raw", r), 32'(if4.raw_o), 32'(p));
    end
    next_frame(1, 16'hFFFF);

    // Stuck-low data pin gives all buttons pressed after two frames
    resync(0);
    next_frame(0, 16'h0000);
    stuck50 = 1'b1;
    next_frame(0, 16'h0000);
    next_frame(0, 16'h0000);
    chk("stuck0_joy1", 32'(if50.joy1_o), 32'h00);
    chk("stuck0_joy2", 32'(if50.joy2_o), 32'h00);

    // Reset asserted while in LOW for bit 7
    wait_pin(0, 0, 1'b1, n);
    for (int i = 0; i < 7; i++) begin
      wait_pin(0, 1, 1'b1, n);
      wait_pin(0, 1, 1'b0, n);
    end
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_joy1",  32'(if50.joy1_o),     32'h3F);
    chk("midrst_joy2",  32'(if50.joy2_o),     32'h3F);
    chk("midrst_raw",   32'(if50.raw_o),      32'hFFFF);
    chk("midrst_load",  32'(if50.joy_load_o), 32'd1);
    chk("midrst_clk",   32'(if50.joy_clk_o),  32'd0);
    chk("midrst_frame", 32'(if50.frame_o),    32'd0);
    repeat (3) @(negedge clk);
    stuck50 = 1'b0;
    pat50   = 16'hFFFF;
    pat4    = 16'hFFFF;
    model_reset();
    rb = rises[0];
    rst = 1'b0;
    wait_pin(0, 0, 1'b0, n);
    chk("restart_load_fall", 32'(n >= 1 && n <= 50), 32'd1);
    chk("restart_no_clk_before_load", 32'(rises[0] - rb), 32'd0);
    cur[0]     = 16'hFFFF;
    started[0] = 1'b1;
    fbase[0]   = fcnt[0];
    wait_pin(0, 0, 1'b1, n);
    chk("restart_load_width", 32'(n), 32'd100);
    next_frame(0, 16'hFFFF);

    chk("load_clk_overlap", 32'(overlap), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/neptuno_joy_shifter.md
Name: neptuno_joy_shifter

Overview:
- Serial front end for the Neptuno twin-joystick port (a pair of cascaded parallel-in/serial-out shift registers on the board).
- Generates the load and shift-clock pins and deserialises the 16-bit frame from the data pin.
- Applies a two-frame agreement filter and presents active-low per-player buttons.
- Directly feeds the Sega 3/6-button stage and the controller's joystick inputs.

Parameters:
- CLK_DIV, 50: system clocks per tick; must be at least 4. Pin rate is clk/(2*CLK_DIV), i.e. 500 kHz at 50 MHz.
- NBITS, 16: bits shifted per frame; fixed at 16, any other value is a compile-time error.

Ports:
- clk_i  in  1  system clock (CLOCK_50 domain)
- rst_i  in  1  reset, asynchronous, active-high
- joy_data_i  in  1  serial data from shift-register QH, asynchronous to clk_i
- joy_load_o  out  1  parallel load, active-low
- joy_clk_o  out  1  shift clock; the register shifts on its rising edge
- joy1_o  out  6  player 1 {fire2,fire1,right,left,down,up}, active-low
- joy2_o  out  6  player 2, same order, active-low
- raw_o  out  16  last accepted frame, bit n = n-th serial bit
- frame_o  out  1  one-cycle strobe per completed frame

Behaviour:
- Reset values:
  - joy_load_o=1, joy_clk_o=0.
  - joy1_o=joy2_o=6'h3F, raw_o=16'hFFFF.
  - frame_o=0; internal previous-frame register=16'hFFFF.
  - The state machine resets to LOAD with the tick counter at 0.
- Reset mid-frame: the frame is abandoned, outputs return to their reset values, and the first frame after release starts at LOAD.
- joy_data_i passes through a 2-FF synchroniser (reset value 1) before any use.
- Tick: a counter runs 0..CLK_DIV-1; the tick asserts on the cycle where the counter equals CLK_DIV-1. All state changes happen only on ticks, except DONE.
- States:
  - LOAD: joy_load_o=0, joy_clk_o=0 for 2 ticks. Then go to LOW with bit index 0.
  - LOW: joy_load_o=1, joy_clk_o=0 for 1 tick. On the tick cycle, the synchronised data is written into shift bit[index]. Then go to HIGH.
  - HIGH: joy_clk_o=1 for 1 tick. On the tick, if index=15 go to DONE, else increment index and go to LOW.
  - DONE: lasts exactly 1 clock and ignores the tick counter. joy_clk_o=0. The frame is evaluated here, then the FSM goes to LOAD with the counter cleared.
- Two-frame agreement filter:
  - In DONE, if shift==prev, then raw_o<=shift, joy1_o<=shift[5:0], joy2_o<=shift[13:8], and frame_o=1 for that cycle.
  - prev<=shift in every DONE, whether or not the frames agree.
  - A disagreeing frame leaves the outputs unchanged and does not strobe frame_o.
  - Consequence: a new button state becomes visible at the end of the second identical frame.
- Frame period is 34*CLK_DIV+1 clocks (1701 at the default).
- Bits 6,7,14,15 appear only on raw_o; they are not decoded.
- Output pins are registered and glitch-free. joy_load_o and joy_clk_o are never low/high in the same cycle.
- Data-pin tie-offs:
  - joy_data_i stuck at 1 gives all released after two frames.
  - Stuck at 0 gives all pressed (6'h00) after two frames.

Decomposition:
- Package neptuno_joy_pkg:
  - state enum {LOAD,LOW,HIGH,DONE}.
  - Bit-position constants JOY1_LSB=0 and JOY2_LSB=8.
  - Bit-offset constants UP=0, DOWN=1, LEFT=2, RIGHT=3, FIRE1=4, FIRE2=5.
  - Localparam FRAME_TICKS=34.
- One sub-module, neptuno_joy_sync: a 2-FF synchroniser with a reset value parameter, reused later for the Sega select line.
- The FSM, tick counter and filter stay in the top module.

Test Plan:
- Reset check: hold rst_i 10 clocks, model drives 16'hFFFF. Required: joy_load_o=1, joy1_o=joy2_o=3F during reset; first joy_load_o fall within CLK_DIV clocks of release; load low for exactly 100 clocks at CLK_DIV=50.
- Pin timing: count joy_clk_o rising edges between load pulses. Required: exactly 16 edges, high and low widths 50 clocks each, frame_o period 1701 clocks.
- Static frame: the shift-register model (shifts on joy_clk_o rise) holds 16'hA5C3. Required: after the 2nd frame, raw_o=A5C3, joy1_o=6'h03, joy2_o=6'h25; no update after the 1st frame.
- Glitch reject: frame N=16'hFFFE (player-1 up), frame N+1=16'hFFFF, then steady FFFF. Required: joy1_o stays 3F throughout and frame_o strobes only on agreeing frames.
- Stuck data: joy_data_i=0 constantly. Required: joy1_o=joy2_o=0 after 2 frames. Then assert rst_i mid-LOW at bit 7. Required: outputs return to 3F immediately (asynchronously) and the new frame starts from LOAD.
- CLK_DIV=4 build with random patterns held 3 frames each. Required: raw_o matches each pattern, with no sampling error caused by synchroniser latency.
